// File: rtl/hzd_pkg.sv
// rtl/hzd_pkg.sv - shared constants, entry layout and latency clamp for the hazard scoreboard
package hzd_pkg;

  localparam int STG_EX   = 1;
  localparam int STG_MEM  = 2;
  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

  // Field widths for the default configuration (DEPTH=2, MAX_LAT=2)
  localparam int ENT_AGE_W = 2;
  localparam int ENT_REM_W = 2;

  typedef struct packed {
    logic                 vld;
    logic [ENT_AGE_W-1:0] age;
    logic [ENT_REM_W-1:0] rem;
  } entryT;

  // A latency of 0 still needs one stage; anything longer saturates at maxLat
  function automatic int clampLat(input int lat, input int maxLat);
    if (lat < 1) return 1;
    if (lat > maxLat) return maxLat;
    return lat;
  endfunction

endpackage

// File: rtl/hzd_sb_entry.sv
// rtl/hzd_sb_entry.sv - one register's in-flight producer record (valid, age, remaining latency)
module hzd_sb_entry
  import hzd_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int STG_W = 2,
  parameter int LAT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             record,
  input  logic [LAT_W-1:0] latIn,
  output logic             vld,
  output logic [STG_W-1:0] age,
  output logic [LAT_W-1:0] rem
);

  // A new record beats the aging update so the youngest producer always wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= 1'b0;
      age <= '0;
      rem <= '0;
    end else if (advance) begin
      if (record) begin
        vld <= 1'b1;
        age <= STG_W'(STG_EX);
        rem <= latIn - LAT_W'(1);
      end else if (vld) begin
        if (age == STG_W'(DEPTH)) begin
          vld <= 1'b0;
          age <= '0;
          rem <= '0;
        end else begin
          age <= age + STG_W'(1);
          if (rem != '0) rem <= rem - LAT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - decode-stage RAW hazard scoreboard with multi-stage forwarding and stall
module hazard_scoreboard
  import hzd_pkg::*;
#(
  parameter  int REG_W   = 3,
  parameter  int NUM_SRC = 2,
  parameter  int DEPTH   = 2,
  parameter  int MAX_LAT = 2,
  localparam int LAT_W   = $clog2(MAX_LAT + 1),
  localparam int STG_W   = $clog2(DEPTH + 1),
  localparam int NREG    = 2 ** REG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*REG_W-1:0] src,
  input  logic [NUM_SRC-1:0]       src_use,
  input  logic                     iss_vld,
  input  logic                     iss_wen,
  input  logic [REG_W-1:0]         iss_wreg,
  input  logic [LAT_W-1:0]         iss_lat,
  input  logic                     flush,
  input  logic                     mem_busy,
  output logic                     do_stall,
  output logic [NUM_SRC-1:0]       fwd_en,
  output logic [NUM_SRC*STG_W-1:0] fwd_sel
);

  logic             entVld [NREG];
  logic [STG_W-1:0] entAge [NREG];
  logic [LAT_W-1:0] entRem [NREG];

  logic             advance;
  logic             recordAny;
  logic             hazard;
  logic [LAT_W-1:0] latClamped;
  logic [REG_W-1:0] srcIdx;

  assign advance    = ~mem_busy;
  assign latClamped = LAT_W'(clampLat(int'(iss_lat), MAX_LAT));

  for (genvar r = 0; r < NREG; r++) begin : gEntry
    hzd_sb_entry #(
      .DEPTH (DEPTH),
      .STG_W (STG_W),
      .LAT_W (LAT_W)
    ) uEntry (
      .clk     (clk),
      .rst     (rst),
      .advance (advance),
      .record  (recordAny && (iss_wreg == REG_W'(r))),
      .latIn   (latClamped),
      .vld     (entVld[r]),
      .age     (entAge[r]),
      .rem     (entRem[r])
    );
  end

  // Sources read the pre-record entries, so an instruction never hazards on itself
  always_comb begin
    hazard  = 1'b0;
    fwd_en  = '0;
    fwd_sel = '0;
    srcIdx  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      srcIdx = src[i*REG_W +: REG_W];
      if (src_use[i] && entVld[srcIdx]) begin
        if (entRem[srcIdx] == '0) begin
          fwd_en[i]                 = 1'b1;
          fwd_sel[i*STG_W +: STG_W] = entAge[srcIdx];
        end else begin
          hazard = 1'b1;
        end
      end
    end
  end

  assign do_stall  = mem_busy | (iss_vld & hazard);
  assign recordAny = iss_vld & iss_wen & ~flush & ~do_stall;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - randomized scoreboard bench for hazard_scoreboard against a tick-count model
module tb_hazard_scoreboard;
  import hzd_pkg::*;

  localparam int DEPTH   = 2;
  localparam int MAX_LAT = 2;

  typedef struct {
    logic       st;
    logic [1:0] en;
    logic [3:0] sel;
  } expT;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] src;
  logic [1:0] src_use;
  logic       iss_vld, iss_wen, flush, mem_busy;
  logic [2:0] iss_wreg;
  logic [1:0] iss_lat;
  logic       do_stall;
  logic [1:0] fwd_en;
  logic [3:0] fwd_sel;

  int  tests = 0;
  int  fails = 0;
  expT expQ[$];

  // Model: a producer recorded at advance-tick t with latency L is visible
  // (tick - t) stages downstream, forwardable once that distance reaches L.
  int tick;
  int tRec[8];
  int latOf[8];
  bit pendAdv, pendRec;
  int pendReg, pendLat;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk      (clk),
    .rst      (rst),
    .src      (src),
    .src_use  (src_use),
    .iss_vld  (iss_vld),
    .iss_wen  (iss_wen),
    .iss_wreg (iss_wreg),
    .iss_lat  (iss_lat),
    .flush    (flush),
    .mem_busy (mem_busy),
    .do_stall (do_stall),
    .fwd_en   (fwd_en),
    .fwd_sel  (fwd_sel)
  );

  function automatic int clampL(input int l);
    return (l < 1) ? 1 : ((l > MAX_LAT) ? MAX_LAT : l);
  endfunction

  function automatic void clearModel();
    for (int r = 0; r < 8; r++) begin
      tRec[r]  = -1000;
      latOf[r] = 1;
    end
    pendAdv = 1'b0;
    pendRec = 1'b0;
  endfunction

  task automatic step(input bit rstNow, input bit v, input bit wen, input int wreg,
                      input int lat, input bit fl, input bit busy,
                      input int s0, input int s1, input bit u0, input bit u1);
    expT e;
    bit  haz;
    int  s, age;
    bit  u;
    @(posedge clk);
    if (!rst && pendAdv) begin
      if (pendRec) begin
        tRec[pendReg]  = tick;
        latOf[pendReg] = pendLat;
      end
      tick++;
    end
    #1;
    iss_vld  = v;
    iss_wen  = wen;
    iss_wreg = 3'(wreg);
    iss_lat  = 2'(lat);
    flush    = fl;
    mem_busy = busy;
    src      = {3'(s1), 3'(s0)};
    src_use  = {u1, u0};
    rst      = rstNow;
    if (rstNow) clearModel();
    e.st = 1'b0; e.en = '0; e.sel = '0;
    haz = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s = (i == 0) ? s0 : s1;
      u = (i == 0) ? u0 : u1;
      age = tick - tRec[s];
      if (u && age >= 1 && age <= DEPTH) begin
        if (age >= latOf[s]) begin
          e.en[i]        = 1'b1;
          e.sel[i*2 +: 2] = 2'(age);
        end else begin
          haz = 1'b1;
        end
      end
    end
    e.st    = busy | (v & haz);
    pendAdv = !busy && !rstNow;
    pendRec = v && wen && !fl && !e.st && !rstNow;
    pendReg = wreg;
    pendLat = clampL(lat);
    expQ.push_back(e);
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      expT e;
      e = expQ.pop_front();
      tests++;
      if (do_stall !== e.st) begin
        fails++;
        $display("FAIL do_stall t=%0t got=%b exp=%b", $time, do_stall, e.st);
      end
      tests++;
      if (fwd_en !== e.en) begin
        fails++;
        $display("FAIL fwd_en t=%0t got=%b exp=%b", $time, fwd_en, e.en);
      end
      tests++;
      if (fwd_sel !== e.sel) begin
        fails++;
        $display("FAIL fwd_sel t=%0t got=%h exp=%h", $time, fwd_sel, e.sel);
      end
    end
  end

  initial begin
    int waited;
    rst = 1'b1; src = '0; src_use = '0; iss_vld = 0; iss_wen = 0;
    iss_wreg = '0; iss_lat = '0; flush = 0; mem_busy = 0;
    tick = 0;
    clearModel();
    repeat (2) @(posedge clk);

    // reset state
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1, 2, 1, 1);
    // ALU dependency: sel 1, then 2, then gone
    step(0, 1, 1, 3, LAT_ALU, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 3, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0, 3, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0, 3, 0, 1, 0);
    // load-use: one stall cycle then forward from MEM
    step(0, 1, 1, 5, LAT_LOAD, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 5, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 0, 5, 0, 1);
    // WAW: younger ALU producer of r2 wins
    step(0, 1, 1, 2, LAT_LOAD, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 2, LAT_ALU, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 2, 2, 1, 1);
    // memory freeze with a load in flight
    step(0, 1, 1, 4, LAT_LOAD, 0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0, 1, 4, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0, 4, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0, 4, 0, 1, 0);
    // flushed write never recorded; stalled write recorded only once released
    step(0, 1, 1, 6, LAT_LOAD, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 6, 6, 1, 1);
    step(0, 1, 1, 1, LAT_LOAD, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 7, LAT_ALU, 0, 0, 1, 0, 1, 0);
    step(0, 1, 1, 7, LAT_ALU, 0, 0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0, 7, 0, 1, 0);
    // latency clamping at both ends
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 3, 0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    // async reset with live entries; unused pending source
    step(0, 1, 1, 3, LAT_LOAD, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0);
    step(0, 1, 1, 5, LAT_ALU, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 5, 3, 1, 1);
    step(0, 1, 0, 0, 0, 0, 0, 5, 3, 1, 1);

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 3), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 4) == 0), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 1), $urandom_range(0, 1));
    end

    waited = 0;
    while (expQ.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    tests++;
    if (expQ.size() > 0) begin
      fails++;
      $display("FAIL drain pending=%0d exp=0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
